// File: rtl/set_assoc_cache.sv
// set_assoc_cache: set-associative, write-back, write-allocate cache with
// one word per line and per-set round-robin replacement.
// Ports:
//   clk, rst (async active-low)
//   req_valid/req_ready/req_write/req_addr/req_wdata   core request
//   resp_valid/resp_hit/resp_rdata                     core response pulse
//   mem_req_valid/ready/write/addr/wdata               memory request (single beat)
//   mem_resp_valid/mem_resp_rdata                      fill data return
module set_assoc_cache #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SETS   = 8,
    parameter int unsigned NUM_WAYS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);

    localparam int unsigned IDX_W  = $clog2(NUM_SETS);
    localparam int unsigned WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned LINE_W = ADDR_WIDTH - 2;
    localparam int unsigned TAG_W  = LINE_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE, COMPARE, WRITEBACK, FILL_REQ, FILL_WAIT, RESPOND
    } state_e;

    state_e                state_q, state_d;
    logic                  wr_q, wr_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [WAY_W-1:0]      victim_q, victim_d;
    logic                  by_ptr_q, by_ptr_d;

    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   valid_d [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_d [NUM_SETS];
    logic [WAY_W-1:0]      ptr_q   [NUM_SETS];
    logic [WAY_W-1:0]      ptr_d   [NUM_SETS];
    logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]      tag_d   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_d  [NUM_SETS][NUM_WAYS];

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim_sel;
    logic                  sel_by_ptr;
    logic [WAY_W-1:0]      ptr_next;

    // Byte offset within the word plays no part in lookup.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    assign idx = line_q[IDX_W-1:0];
    assign tag = line_q[LINE_W-1:IDX_W];

    // Tag lookup and victim choice: lowest invalid way, else the set's pointer.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim_sel = ptr_q[idx];
        sel_by_ptr = 1'b1;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx][WAY_W'(w)] && (tag_q[idx][WAY_W'(w)] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][WAY_W'(w)]) begin
                victim_sel = WAY_W'(w);
                sel_by_ptr = 1'b0;
            end
        end
        ptr_next = (ptr_q[idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : ptr_q[idx] + WAY_W'(1);
    end

    // Next state, array updates and outputs.
    always_comb begin
        state_d       = state_q;
        wr_d          = wr_q;
        line_d        = line_q;
        wdata_d       = wdata_q;
        victim_d      = victim_q;
        by_ptr_d      = by_ptr_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        ptr_d         = ptr_q;
        tag_d         = tag_q;
        data_d        = data_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_hit      = 1'b0;
        resp_rdata    = '0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wr_d    = req_write;
                    line_d  = req_addr[ADDR_WIDTH-1:2];
                    wdata_d = req_wdata;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    resp_hit   = 1'b1;
                    if (wr_q) begin
                        data_d[idx][hit_way]  = wdata_q;
                        dirty_d[idx][hit_way] = 1'b1;
                        resp_rdata            = wdata_q;
                    end else begin
                        resp_rdata = data_q[idx][hit_way];
                    end
                    state_d = IDLE;
                end else begin
                    victim_d = victim_sel;
                    by_ptr_d = sel_by_ptr;
                    state_d  = (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel])
                               ? WRITEBACK : FILL_REQ;
                end
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {tag_q[idx][victim_q], idx, 2'b00};
                mem_req_wdata = data_q[idx][victim_q];
                if (mem_req_ready) begin
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {line_q, 2'b00};
                if (mem_req_ready) begin
                    state_d = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (mem_resp_valid) begin
                    valid_d[idx][victim_q] = 1'b1;
                    dirty_d[idx][victim_q] = 1'b0;
                    tag_d[idx][victim_q]   = tag;
                    data_d[idx][victim_q]  = mem_resp_rdata;
                    if (by_ptr_q) begin
                        ptr_d[idx] = ptr_next;
                    end
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                resp_valid = 1'b1;
                if (wr_q) begin
                    data_d[idx][victim_q]  = wdata_q;
                    dirty_d[idx][victim_q] = 1'b1;
                    resp_rdata             = wdata_q;
                end else begin
                    resp_rdata = data_q[idx][victim_q];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and line status bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            line_q   <= '0;
            wdata_q  <= '0;
            victim_q <= '0;
            by_ptr_q <= 1'b0;
            valid_q  <= '{default: '0};
            dirty_q  <= '{default: '0};
            ptr_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            line_q   <= line_d;
            wdata_q  <= wdata_d;
            victim_q <= victim_d;
            by_ptr_q <= by_ptr_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            ptr_q    <= ptr_d;
        end
    end

    // Tag and data storage; contents are qualified by valid, so no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised set-associative, write-back, write-allocate cache with a request/response handshake on the core side and a single-beat valid/ready port to backing memory. It generalises the fixed single-configuration cache memory: configurable set count, associativity and widths, per-set round-robin replacement, dirty-line writeback and miss handling with backpressure. It sits between the core load/store path and data memory.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word and line width (one word per line)
- NUM_SETS, 8, number of sets, power of 2, at least 2
- NUM_WAYS, 2, ways per set, power of 2, at least 1
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  cache can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- req_wdata  in  DATA_WIDTH  store data
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  response was a hit (valid with resp_valid)
- resp_rdata  out  DATA_WIDTH  load data, or stored data for stores
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1 = writeback, 0 = fill read
- mem_req_addr  out  ADDR_WIDTH  word-aligned line address
- mem_req_wdata  out  DATA_WIDTH  writeback data
- mem_resp_valid  in  1  fill data valid
- mem_resp_rdata  in  DATA_WIDTH  fill data

## Operation
- Address split: index = addr[2 +: log2(NUM_SETS)]; tag = bits above index; bits [1:0] ignored.
- Per line: valid, dirty, tag, data. Per set: round-robin victim pointer, log2(NUM_WAYS) bits.
- FSM states: IDLE, COMPARE, WRITEBACK, FILL_REQ, FILL_WAIT, RESPOND.
- IDLE: req_ready = 1. On req_valid, latch write, addr and wdata, then go to COMPARE.
- COMPARE hit, i.e. a valid way whose tag matches:
  - resp_valid = 1 and resp_hit = 1.
  - Load: resp_rdata = line data.
  - Store: write the line, set dirty, resp_rdata = wdata.
  - Next state IDLE.
- COMPARE miss: the victim is the first invalid way (lowest index). If all ways are valid, the victim is the way at the round-robin pointer.
  - Victim valid and dirty: go to WRITEBACK.
  - Otherwise: go to FILL_REQ.
- WRITEBACK: mem_req_valid = 1, mem_req_write = 1, mem_req_addr = {victim tag, index, 2'b00}, mem_req_wdata = victim data. On mem_req_ready, go to FILL_REQ. A writeback receives no response.
- FILL_REQ: mem_req_valid = 1, mem_req_write = 0, mem_req_addr = {req tag, index, 2'b00}. On mem_req_ready, go to FILL_WAIT.
- FILL_WAIT: on mem_resp_valid, install the victim way: valid = 1, dirty = 0, tag = req tag, data = mem_resp_rdata. Advance that set's pointer (mod NUM_WAYS) only if the victim was chosen by the pointer. Go to RESPOND.
- RESPOND: resp_valid = 1, resp_hit = 0.
  - Load: resp_rdata = fill data.
  - Store: overwrite the line, set dirty, resp_rdata = wdata.
  - Next state IDLE.
- mem_resp_valid outside FILL_WAIT is ignored. req_valid outside IDLE is not accepted.

## Timing
- Reset: state IDLE, all valid and dirty bits 0, pointers 0. All outputs 0 except req_ready = 1.
  - Reset takes effect immediately (asynchronous). Asserting it mid-miss drops mem_req_valid at once and abandons the request with no response.
- Hit latency: accept at edge N, resp_valid high in cycle N+1, 2 cycles minimum per request.
- Clean miss: accept, COMPARE, FILL_REQ (at least 1 cycle), FILL_WAIT (at least 1 cycle), RESPOND. A dirty miss adds WRITEBACK (at least 1 cycle).
- While mem_req_valid is high and mem_req_ready is low, mem_req_addr, mem_req_write and mem_req_wdata stay stable.
- resp_* outputs are combinational from the state and registered data; resp_valid is exactly one cycle wide.
- Configuration NUM_WAYS = 1: direct-mapped; the pointer is unused.

## Test plan
All scenarios use NUM_SETS = 8 and NUM_WAYS = 2, so index = addr[4:2].
- Reset, then load 0x1C -> one fill read at 0x1C. Memory returns 0xCAFE -> resp_valid with 0xCAFE and resp_hit = 0. Reload 0x1C -> resp_valid in cycle N+1 with 0xCAFE, resp_hit = 1, no memory traffic.
- Store 0x0A to 0x1C after the fill -> hit, resp_hit = 1. Load 0x1C -> 0x0A, no memory traffic.
- Load 0x3C then 0x5C (all three addresses in set 7) -> the 0x5C miss first issues a writeback: addr 0x1C, data 0x0A, then a fill read of 0x5C. A later load of 0x1C evicts way 1 (0x3C, clean): fill only, no writeback.
- Hold mem_req_ready low for 5 cycles during FILL_REQ -> mem_req_valid stays high and mem_req_addr stays 0x1C each cycle. req_ready = 0 and a concurrent req_valid is not accepted.
- Assert rst during FILL_WAIT -> mem_req_valid, resp_valid and all other outputs 0 before the next edge; no response is issued. After release, load 0x1C -> miss (resp_hit = 0).
- Store to 0x40 on a cold cache -> fill read at 0x40, then RESPOND with resp_hit = 0. The line is dirty: a later conflicting eviction of it produces a writeback carrying the stored data.
